// File: rtl/range_sweep_ctrl.sv
// Triangle-sweep initiator for a MIN..MAX-1 range up/down/load counter.
// Define SWEEP_CHECK_EN to enable the shadow checker that drives the sticky err flag.
module range_sweep_ctrl #(
    parameter int WIDTH = 6,
    parameter int MIN   = 10,
    parameter int MAX   = 40,
    parameter int NW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [NW-1:0]    n_sweeps,
    input  logic [WIDTH-1:0] count_in,
    output logic             load,
    output logic [WIDTH-1:0] data,
    output logic             u_d,
    output logic             busy,
    output logic             done,
    output logic             bad_cfg,
    output logic [NW-1:0]    sweep_cnt,
    output logic             err
);

    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] TOP_V = WIDTH'(MAX - 1);
    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [NW-1:0]    ONE_N = {{(NW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        UP   = 2'd2,
        DOWN = 2'd3
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] exp_r;
    logic [NW-1:0]    n_r;

    logic [WIDTH-1:0] lo_c_s;
    logic [WIDTH-1:0] hi_c_s;
    logic             cfg_ok_s;
    logic             accept_s;
    logic [WIDTH-1:0] exp_inc_s;
    logic [WIDTH-1:0] exp_dec_s;
    logic [NW-1:0]    sweep_inc_s;

    // Clamp the requested bounds into the counter's legal range and precompute next values.
    always_comb begin
        lo_c_s      = (lo < MIN_V) ? MIN_V : lo;
        hi_c_s      = (hi > TOP_V) ? TOP_V : hi;
        cfg_ok_s    = (lo_c_s < hi_c_s) && (n_sweeps != {NW{1'b0}});
        accept_s    = (state_r == IDLE) && start && cfg_ok_s;
        exp_inc_s   = exp_r + ONE_W;
        exp_dec_s   = exp_r - ONE_W;
        sweep_inc_s = sweep_cnt + ONE_N;
    end

    // Sweep sequencer; stop pre-empts every busy-state transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            lo_r      <= {WIDTH{1'b0}};
            hi_r      <= {WIDTH{1'b0}};
            exp_r     <= {WIDTH{1'b0}};
            n_r       <= {NW{1'b0}};
            load      <= 1'b0;
            data      <= {WIDTH{1'b0}};
            u_d       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            bad_cfg   <= 1'b0;
            sweep_cnt <= {NW{1'b0}};
        end else begin
            done    <= 1'b0;
            bad_cfg <= 1'b0;
            if (state_r != IDLE && stop) begin
                state_r <= IDLE;
                load    <= 1'b0;
                u_d     <= 1'b1;
                busy    <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        load <= 1'b0;
                        u_d  <= 1'b1;
                        if (accept_s) begin
                            lo_r      <= lo_c_s;
                            hi_r      <= hi_c_s;
                            n_r       <= n_sweeps;
                            sweep_cnt <= {NW{1'b0}};
                            data      <= lo_c_s;
                            load      <= 1'b1;
                            busy      <= 1'b1;
                            state_r   <= LOAD;
                        end else if (start) begin
                            bad_cfg <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    LOAD: begin
                        load    <= 1'b0;
                        u_d     <= 1'b1;
                        exp_r   <= lo_r;
                        state_r <= UP;
                    end
                    UP: begin
                        exp_r <= exp_inc_s;
                        if (exp_inc_s == hi_r) begin
                            u_d     <= 1'b0;
                            state_r <= DOWN;
                        end else begin
                            u_d <= 1'b1;
                        end
                    end
                    DOWN: begin
                        exp_r <= exp_dec_s;
                        if (exp_dec_s == lo_r) begin
                            sweep_cnt <= sweep_inc_s;
                            u_d       <= 1'b1;
                            if (sweep_inc_s == n_r) begin
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                state_r <= IDLE;
                            end else begin
                                state_r <= UP;
                            end
                        end else begin
                            u_d <= 1'b0;
                        end
                    end
                    default: begin
                        load    <= 1'b0;
                        u_d     <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef SWEEP_CHECK_EN
    // Sticky shadow check of the counter against the expected value while sweeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept_s) begin
            err <= 1'b0;
        end else if ((state_r == UP || state_r == DOWN) && (count_in != exp_r)) begin
            err <= 1'b1;
        end else begin
            err <= err;
        end
    end
`else
    logic unused_count_s;
    assign unused_count_s = ^count_in;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_range_sweep_ctrl.sv
// Directed self-checking bench for range_sweep_ctrl driving an ideal 10..39 range counter model.
module tb_range_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic [5:0] lo;
    logic [5:0] hi;
    logic [3:0] n_sweeps;
    logic [5:0] count_in;
    logic       load;
    logic [5:0] data;
    logic       u_d;
    logic       busy;
    logic       done;
    logic       bad_cfg;
    logic [3:0] sweep_cnt;
    logic       err;

    logic [5:0] cnt;
    logic       force_en = 1'b0;
    int         total = 0;
    int         bad = 0;

`ifdef SWEEP_CHECK_EN
    localparam logic CHECK_ON = 1'b1;
`else
    localparam logic CHECK_ON = 1'b0;
`endif

    range_sweep_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .lo(lo), .hi(hi), .n_sweeps(n_sweeps), .count_in(count_in),
        .load(load), .data(data), .u_d(u_d), .busy(busy), .done(done),
        .bad_cfg(bad_cfg), .sweep_cnt(sweep_cnt), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] ctr_next(input logic [5:0] c, input logic ld,
                                            input logic [5:0] d, input logic up);
        logic [5:0] n;
        if (ld)      n = d;
        else if (up) n = c + 6'd1;
        else         n = c - 6'd1;
        if (n < 6'd10 || n >= 6'd40) n = 6'd10;
        return n;
    endfunction

    // Ideal range counter; the fault hook corrupts the observed value 16 -> 17.
    always @(posedge clk) begin
        if (rst) cnt <= 6'd10;
        else     cnt <= ctr_next(cnt, load, data, u_d);
    end
    assign count_in = (force_en && cnt == 6'd16) ? 6'd17 : cnt;

    task automatic kick(input logic [5:0] l, input logic [5:0] h, input logic [3:0] n);
        lo = l; hi = h; n_sweeps = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; lo = 6'd0; hi = 6'd0; n_sweeps = 4'd0;
        repeat (2) @(negedge clk);
        total++;
        if (load !== 1'b0 || data !== 6'd0 || u_d !== 1'b1 || busy !== 1'b0 ||
            done !== 1'b0 || bad_cfg !== 1'b0 || sweep_cnt !== 4'd0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset: load=%b data=%0d u_d=%b busy=%b done=%b bad_cfg=%b sweep_cnt=%0d err=%b, want 0 0 1 0 0 0 0 0",
                     load, data, u_d, busy, done, bad_cfg, sweep_cnt, err);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_sweep();
        logic [5:0] exp_seq [7] = '{6'd12, 6'd13, 6'd14, 6'd15, 6'd14, 6'd13, 6'd12};
        int bc;
        kick(6'd12, 6'd15, 4'd1);
        total++;
        if (load !== 1'b1 || data !== 6'd12 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_load: load=%b data=%0d busy=%b, want 1 12 1", load, data, busy);
        end
        bc = 1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (busy === 1'b1) bc++;
            total++;
            if (count_in !== exp_seq[i]) begin
                bad++;
                $display("FAIL single_count[%0d]: got %0d want %0d", i, count_in, exp_seq[i]);
            end
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || bc != 7 || sweep_cnt !== 4'd1) begin
            bad++;
            $display("FAIL single_end: done=%b busy=%b busy_cycles=%0d sweep_cnt=%0d, want 1 0 7 1",
                     done, busy, bc, sweep_cnt);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL single_done_pulse: done=%b want 0", done);
        end
    endtask

    task automatic test_clamp();
        int bc = 0;
        int guard = 0;
        logic [5:0] peak = 6'd0;
        kick(6'd3, 6'd45, 4'd2);
        total++;
        if (load !== 1'b1 || data !== 6'd10) begin
            bad++;
            $display("FAIL clamp_load: load=%b data=%0d want 1 10", load, data);
        end
        while (busy === 1'b1 && guard < 400) begin
            bc++;
            if (load === 1'b0 && count_in > peak) peak = count_in;
            @(negedge clk);
            guard++;
        end
        total++;
        if (bc != 117 || peak !== 6'd39 || done !== 1'b1 || sweep_cnt !== 4'd2) begin
            bad++;
            $display("FAIL clamp_run: busy_cycles=%0d peak=%0d done=%b sweep_cnt=%0d, want 117 39 1 2",
                     bc, peak, done, sweep_cnt);
        end
    endtask

    task automatic test_reject();
        logic [5:0] lv [3] = '{6'd20, 6'd10, 6'd50};
        logic [5:0] hv [3] = '{6'd20, 6'd20, 6'd60};
        logic [3:0] nv [3] = '{4'd1, 4'd0, 4'd1};
        for (int i = 0; i < 3; i++) begin
            kick(lv[i], hv[i], nv[i]);
            total++;
            if (bad_cfg !== 1'b1 || busy !== 1'b0 || load !== 1'b0) begin
                bad++;
                $display("FAIL reject[%0d]: bad_cfg=%b busy=%b load=%b, want 1 0 0", i, bad_cfg, busy, load);
            end
            @(negedge clk);
            total++;
            if (bad_cfg !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reject_pulse[%0d]: bad_cfg=%b busy=%b, want 0 0", i, bad_cfg, busy);
            end
        end
    endtask

    task automatic test_start_priority();
        int bc;
        int guard = 0;
        stop = 1'b1;
        kick(6'd12, 6'd15, 4'd1);
        stop = 1'b0;
        total++;
        if (busy !== 1'b1 || data !== 6'd12) begin
            bad++;
            $display("FAIL start_over_stop: busy=%b data=%0d, want 1 12", busy, data);
        end
        bc = 1;
        @(negedge clk);
        if (busy === 1'b1) bc++;
        kick(6'd20, 6'd30, 4'd5);
        while (busy === 1'b1 && guard < 50) begin
            bc++;
            @(negedge clk);
            guard++;
        end
        total++;
        if (bc != 7 || done !== 1'b1 || sweep_cnt !== 4'd1 || data !== 6'd12) begin
            bad++;
            $display("FAIL start_while_busy: busy_cycles=%0d done=%b sweep_cnt=%0d data=%0d, want 7 1 1 12",
                     bc, done, sweep_cnt, data);
        end
    endtask

    task automatic test_stop();
        int guard = 0;
        kick(6'd10, 6'd30, 4'd3);
        while (!(busy === 1'b1 && load === 1'b0 && u_d === 1'b1 && count_in == 6'd25) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        total++;
        if (guard >= 100 || busy !== 1'b0 || done !== 1'b0 || sweep_cnt !== 4'd0 || load !== 1'b0 || u_d !== 1'b1) begin
            bad++;
            $display("FAIL stop_up: guard=%0d busy=%b done=%b sweep_cnt=%0d load=%b u_d=%b, want busy=0 done=0 cnt=0 load=0 u_d=1",
                     guard, busy, done, sweep_cnt, load, u_d);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL stop_up_after: done=%b busy=%b want 0 0", done, busy);
        end

        guard = 0;
        kick(6'd10, 6'd30, 4'd3);
        while (!(busy === 1'b1 && u_d === 1'b0 && sweep_cnt == 4'd2 && count_in == 6'd11) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        total++;
        if (guard >= 300 || busy !== 1'b0 || done !== 1'b0 || sweep_cnt !== 4'd2) begin
            bad++;
            $display("FAIL stop_final_edge: guard=%0d busy=%b done=%b sweep_cnt=%0d, want busy=0 done=0 cnt=2",
                     guard, busy, done, sweep_cnt);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL stop_final_after: done=%b want 0", done);
        end
    endtask

    task automatic test_mid_reset();
        kick(6'd10, 6'd20, 4'd2);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || load !== 1'b0 || u_d !== 1'b1 || sweep_cnt !== 4'd0 || data !== 6'd0 || done !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: busy=%b load=%b u_d=%b sweep_cnt=%0d data=%0d done=%b, want 0 0 1 0 0 0",
                     busy, load, u_d, sweep_cnt, data, done);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_after: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_check();
        int guard = 0;
        force_en = 1'b1;
        kick(6'd10, 6'd20, 4'd1);
        while (busy === 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        force_en = 1'b0;
        @(negedge clk);
        total++;
        if (err !== CHECK_ON || done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL check_err_set: err=%b done=%b busy=%b, want err=%b done=0 busy=0", err, done, busy, CHECK_ON);
        end
        kick(6'd10, 6'd20, 4'd1);
        total++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL check_err_clear: err=%b busy=%b, want 0 1", err, busy);
        end
        guard = 0;
        while (busy === 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (err !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL check_clean_run: err=%b done=%b, want 0 1", err, done);
        end
    endtask

    initial begin
        test_reset();
        test_single_sweep();
        test_clamp();
        test_reject();
        test_start_priority();
        test_stop();
        test_mid_reset();
        test_check();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
